// File: rtl/queue_calc_seq.sv
// Instruction sequencer for the queue calculator: pops operands from an external
// FIFO, computes PUSH/POP/ADD/MUL/SUB/DIV/REM and pushes results back.
module queue_calc_seq #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    instr_op,
    input  logic [7:0]    instr_imm,
    input  logic [CW-1:0] q_count,
    input  logic [7:0]    q_dout,
    output logic          q_pop,
    output logic          q_push,
    output logic [7:0]    q_din,
    output logic [7:0]    result,
    output logic          done,
    output logic          busy,
    output logic          err,
    output logic [1:0]    err_code,
    input  logic          err_clr,
    output logic [2:0]    state_dbg
);

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both high; instr_ready is high only in IDLE with rst low.

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_POP_B, S_EXEC, S_DONE, S_ERROR
    } state_t;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t      state;
    logic [3:0]  op;
    logic [7:0]  imm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic [7:0]  alu;
    logic        is_push;
    logic        is_pop;
    logic        is_bin;
    logic        is_ill;
    logic        is_divrem;
    logic        q_empty;
    logic        q_full;
    logic        q_has_two;

    assign is_push   = (op == 4'd0);
    assign is_pop    = (op == 4'd1);
    assign is_bin    = (op >= 4'd2) && (op <= 4'd6);
    assign is_ill    = (op == 4'd7);
    assign is_divrem = (op == 4'd5) || (op == 4'd6);
    assign q_empty   = (q_count == CW'(0));
    assign q_full    = (q_count == FULL);
    assign q_has_two = (q_count >= CW'(2));
    assign prod      = 16'(a) * 16'(b);

    always_comb begin
        alu = 8'h00;
        case (op)
            4'd2:    alu = a + b;
            4'd3:    alu = prod[7:0];
            4'd4:    alu = a - b;
            4'd5:    alu = (b == 8'h00) ? 8'h00 : a / b;
            4'd6:    alu = (b == 8'h00) ? 8'h00 : a % b;
            default: alu = 8'h00;
        endcase
    end

    // Strobes are decoded from the current state so the queue moves on the same
    // edge the sequencer leaves that state; reset suppresses them immediately.
    always_comb begin
        q_pop  = 1'b0;
        q_push = 1'b0;
        q_din  = 8'h00;
        if (!rst) begin
            case (state)
                S_DECODE: begin
                    if (is_push && !q_full) begin
                        q_push = 1'b1;
                        q_din  = imm;
                    end else if (is_pop && !q_empty) begin
                        q_pop = 1'b1;
                    end else if (is_bin && q_has_two) begin
                        q_pop = 1'b1;
                    end
                end
                S_POP_B: q_pop = 1'b1;
                S_EXEC: begin
                    if (!(is_divrem && b == 8'h00)) begin
                        q_push = 1'b1;
                        q_din  = alu;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op       <= 4'd0;
            imm      <= 8'h00;
            a        <= 8'h00;
            b        <= 8'h00;
            result   <= 8'h00;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        op    <= instr_op;
                        imm   <= instr_imm;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_ill) begin
                        state <= S_ERROR; err <= 1'b1; err_code <= 2'd0;
                    end else if (is_push) begin
                        if (q_full) begin
                            state <= S_ERROR; err <= 1'b1; err_code <= 2'd2;
                        end else begin
                            result <= imm; done <= 1'b1; state <= S_DONE;
                        end
                    end else if (is_pop) begin
                        if (q_empty) begin
                            state <= S_ERROR; err <= 1'b1; err_code <= 2'd1;
                        end else begin
                            result <= q_dout; done <= 1'b1; state <= S_DONE;
                        end
                    end else if (is_bin) begin
                        if (!q_has_two) begin
                            state <= S_ERROR; err <= 1'b1; err_code <= 2'd1;
                        end else begin
                            a <= q_dout; state <= S_POP_B;
                        end
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_POP_B: begin
                    b     <= q_dout;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    // Both operands are already gone, so a zero divisor pushes nothing.
                    if (is_divrem && b == 8'h00) begin
                        state <= S_ERROR; err <= 1'b1; err_code <= 2'd3;
                    end else begin
                        result <= alu; done <= 1'b1; state <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                S_ERROR: begin
                    if (err_clr) begin
                        state <= S_IDLE; err <= 1'b0; err_code <= 2'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = (state == S_IDLE) && !rst;
    assign busy        = (state != S_IDLE);
    assign state_dbg   = state;

endmodule

// File: tb/tb_queue_calc_seq.sv
// Bench for queue_calc_seq: a behavioural FIFO stands in for the operand queue;
// a vector table plus hand sequences cover errors, err_clr and reset mid-instruction.
module tb_queue_calc_seq;

    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    instr_op;
    logic [7:0]    instr_imm;
    logic [CW-1:0] q_count;
    logic [7:0]    q_dout;
    logic          q_pop;
    logic          q_push;
    logic [7:0]    q_din;
    logic [7:0]    result;
    logic          done;
    logic          busy;
    logic          err;
    logic [1:0]    err_code;
    logic          err_clr;
    logic [2:0]    state_dbg;

    always #5 clk = ~clk;

    queue_calc_seq #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_imm(instr_imm), .q_count(q_count), .q_dout(q_dout),
        .q_pop(q_pop), .q_push(q_push), .q_din(q_din), .result(result), .done(done),
        .busy(busy), .err(err), .err_code(err_code), .err_clr(err_clr),
        .state_dbg(state_dbg)
    );

    // Operand FIFO model
    logic [7:0]    fifo_mem [DEPTH];
    logic [3:0]    fifo_head;
    logic [3:0]    fifo_wr;
    logic [CW-1:0] fifo_cnt;
    logic          flush;

    assign fifo_wr = fifo_head + fifo_cnt[3:0];
    assign q_count = fifo_cnt;
    assign q_dout  = fifo_mem[fifo_head];

    always @(posedge clk) begin
        if (flush) begin
            fifo_head <= 4'd0;
            fifo_cnt  <= '0;
        end else if (q_push && fifo_cnt != CW'(DEPTH)) begin
            fifo_mem[fifo_wr] <= q_din;
            fifo_cnt          <= fifo_cnt + CW'(1);
        end else if (q_pop && fifo_cnt != '0) begin
            fifo_head <= fifo_head + 4'd1;
            fifo_cnt  <= fifo_cnt - CW'(1);
        end
    end

    logic [7:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    typedef struct {
        string name;
        int op, imm, pre_n, p0, p1;
        int lat, pops, pushes, din, e, code, res, cnt;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(string nm, int op, int imm, int pre_n, int p0, int p1,
                                int lat, int pops, int pushes, int din, int e, int code,
                                int res, int cnt);
        vec_t v;
        v.name = nm; v.op = op; v.imm = imm; v.pre_n = pre_n; v.p0 = p0; v.p1 = p1;
        v.lat = lat; v.pops = pops; v.pushes = pushes; v.din = din; v.e = e;
        v.code = code; v.res = res; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b1; err_clr = 1'b0; instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; flush = 1'b0;
        exp_q.delete();
    endtask

    // Offer one instruction, then watch strobes until done or err (bounded).
    task automatic issue(input logic [3:0] op, input logic [7:0] imm, input bit exp_push,
                         input logic [7:0] exp_val, output int lat, output int pushes,
                         output int pops);
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", int'(instr_ready), 1);
        if (exp_push) exp_q.push_back(exp_val);
        instr_valid = 1'b1; instr_op = op; instr_imm = imm;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        lat = -1; pushes = 0; pops = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (q_push) begin
                pushes++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_push: got q_din=%0d expected no push", q_din);
                end else begin
                    chk("push_data", int'(q_din), int'(exp_q.pop_front()));
                end
            end
            if (q_pop) pops++;
            if (done || err) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pu, po;
        vec_t v;

        vecs[0]  = mk("sub",       4, 0,  2, 7,   5,   4, 2, 1, 2,   0, 0, 2,   1);
        vecs[1]  = mk("add_wrap",  2, 0,  2, 200, 100, 4, 2, 1, 44,  0, 0, 44,  1);
        vecs[2]  = mk("mul_zero",  3, 0,  2, 16,  16,  4, 2, 1, 0,   0, 0, 0,   1);
        vecs[3]  = mk("mul",       3, 0,  2, 13,  11,  4, 2, 1, 143, 0, 0, 143, 1);
        vecs[4]  = mk("div_zero",  5, 0,  2, 9,   0,   4, 2, 0, 0,   1, 3, 0,   0);
        vecs[5]  = mk("div",       5, 0,  2, 100, 7,   4, 2, 1, 14,  0, 0, 14,  1);
        vecs[6]  = mk("rem",       6, 0,  2, 100, 7,   4, 2, 1, 2,   0, 0, 2,   1);
        vecs[7]  = mk("rem_zero",  6, 0,  2, 5,   0,   4, 2, 0, 0,   1, 3, 0,   0);
        vecs[8]  = mk("pop_empty", 1, 0,  0, 0,   0,   2, 0, 0, 0,   1, 1, 0,   0);
        vecs[9]  = mk("add_under", 2, 0,  1, 9,   0,   2, 0, 0, 0,   1, 1, 9,   1);
        vecs[10] = mk("push_full", 0, 3,  16, 0,  0,   2, 0, 0, 0,   1, 2, 15,  16);
        vecs[11] = mk("illegal",   7, 0,  0, 0,   0,   2, 0, 0, 0,   1, 0, 0,   0);
        vecs[12] = mk("nop",       12, 0, 1, 55,  0,   2, 0, 0, 0,   0, 0, 55,  1);
        vecs[13] = mk("pop",       1, 0,  1, 42,  0,   2, 1, 0, 0,   0, 0, 42,  0);
        vecs[14] = mk("push",      0, 77, 0, 0,   0,   2, 0, 1, 77,  0, 0, 77,  1);
        vecs[15] = mk("sub_wrap",  4, 0,  2, 5,   7,   4, 2, 1, 254, 0, 0, 254, 1);

        // Reset state, with an instruction offered during reset
        rst = 1'b1; flush = 1'b1; err_clr = 1'b0;
        instr_valid = 1'b1; instr_op = 4'd0; instr_imm = 8'd99;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(instr_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_push", int'(q_push), 0);
        @(posedge clk);
        #1 rst = 1'b0; flush = 1'b0; instr_valid = 1'b0;
        @(negedge clk);
        chk("idle_ready", int'(instr_ready), 1);

        for (int i = 0; i < 16; i++) begin
            v = vecs[i];
            do_reset();
            if (v.pre_n == DEPTH) begin
                for (int k = 0; k < DEPTH; k++) issue(4'd0, 8'(k), 1'b1, 8'(k), lat, pu, po);
            end else begin
                if (v.pre_n >= 1) issue(4'd0, 8'(v.p0), 1'b1, 8'(v.p0), lat, pu, po);
                if (v.pre_n >= 2) issue(4'd0, 8'(v.p1), 1'b1, 8'(v.p1), lat, pu, po);
            end
            issue(4'(v.op), 8'(v.imm), v.pushes == 1, 8'(v.din), lat, pu, po);
            chk({v.name, "_latency"}, lat, v.lat);
            chk({v.name, "_pops"}, po, v.pops);
            chk({v.name, "_pushes"}, pu, v.pushes);
            chk({v.name, "_err"}, int'(err), v.e);
            if (v.e != 0) begin
                chk({v.name, "_err_code"}, int'(err_code), v.code);
                chk({v.name, "_ready_in_err"}, int'(instr_ready), 0);
            end
            chk({v.name, "_result"}, int'(result), v.res);
            chk({v.name, "_q_count"}, int'(q_count), v.cnt);
            chk({v.name, "_sb_drained"}, exp_q.size(), 0);
            if (v.e != 0) begin
                err_clr = 1'b1;
                @(posedge clk);
                #1 err_clr = 1'b0;
            end
        end

        // Divide by zero, then err_clr with an instruction already offered
        do_reset();
        issue(4'd0, 8'd9, 1'b1, 8'd9, lat, pu, po);
        issue(4'd0, 8'd0, 1'b1, 8'd0, lat, pu, po);
        issue(4'd5, 8'd0, 1'b0, 8'd0, lat, pu, po);
        chk("dz_err", int'(err), 1);
        chk("dz_code", int'(err_code), 3);
        instr_valid = 1'b1; instr_op = 4'd0; instr_imm = 8'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("dz_hold_ready", int'(instr_ready), 0);
            chk("dz_hold_push", int'(q_push), 0);
            chk("dz_hold_err", int'(err), 1);
        end
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0; instr_valid = 1'b0;
        @(negedge clk);
        chk("clr_err", int'(err), 0);
        chk("clr_code", int'(err_code), 0);
        chk("clr_not_accepted", int'(busy), 0);
        chk("clr_ready", int'(instr_ready), 1);
        issue(4'd0, 8'd1, 1'b1, 8'd1, lat, pu, po);
        chk("clr_push_latency", lat, 2);
        chk("clr_push_result", int'(result), 1);
        chk("clr_push_count", int'(q_count), 1);

        // Reset during POP_B of a MUL
        do_reset();
        issue(4'd0, 8'd3, 1'b1, 8'd3, lat, pu, po);
        issue(4'd0, 8'd4, 1'b1, 8'd4, lat, pu, po);
        @(negedge clk);
        chk("mr_ready", int'(instr_ready), 1);
        instr_valid = 1'b1; instr_op = 4'd3; instr_imm = 8'd0;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk("mr_first_pop", int'(q_pop), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mr_popb_no_pop", int'(q_pop), 0);
        chk("mr_popb_no_push", int'(q_push), 0);
        @(posedge clk);
        @(negedge clk);
        chk("mr_result", int'(result), 0);
        chk("mr_done", int'(done), 0);
        chk("mr_err", int'(err), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_ready_in_rst", int'(instr_ready), 0);
        chk("mr_pop", int'(q_pop), 0);
        chk("mr_q_count", int'(q_count), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        issue(4'd0, 8'd1, 1'b1, 8'd1, lat, pu, po);
        chk("mr_push_latency", lat, 2);
        chk("mr_push_pops", po, 0);
        chk("mr_push_result", int'(result), 1);
        chk("mr_push_count", int'(q_count), 2);
        chk("mr_sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/queue_calc_seq.md
# queue_calc_seq

Instruction sequencer for the queue calculator. Accepts one 4-bit opcode plus 8-bit immediate at a time over a valid/ready handshake. Runs each instruction against an external 8-bit FIFO operand queue: pops operands, computes the result, pushes it back. Reports a sticky error on queue underflow or overflow, divide-by-zero, or an illegal opcode.

## Interface
- DEPTH, 16: capacity of the attached operand queue, in entries.
- CW, 5: width of `q_count`. Must satisfy 2^CW > DEPTH.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_op  in  4  opcode: 0 PUSH, 1 POP, 2 ADD, 3 MUL, 4 SUB, 5 DIV, 6 REM, 8–15 NOP, 7 illegal.
- instr_imm  in  8  push value; used by PUSH only.
- q_count  in  CW  current queue occupancy.
- q_dout  in  8  queue head, combinational; valid while `q_count` > 0.
- q_pop  out  1  consume the head at this edge.
- q_push  out  1  write `q_din` at this edge.
- q_din  out  8  push data.
- result  out  8  last pushed or popped value.
- done  out  1  one-cycle pulse: instruction retired.
- busy  out  1  state is not IDLE.
- err  out  1  sticky error flag.
- err_code  out  2  1 underflow, 2 overflow, 3 divide-by-zero, 0 illegal opcode; meaningful only while `err` = 1.
- err_clr  in  1  leave ERROR.

## Operation
- **States:** IDLE, DECODE, POP_B, EXEC, DONE, ERROR.
- **IDLE:** `instr_ready` = 1 when `rst` = 0. On `instr_valid & instr_ready`, latch op and imm, then go to DECODE.
- **DECODE, PUSH:**
  - `q_count` == DEPTH → ERROR, code 2.
  - Otherwise assert `q_push`, `q_din` = imm, `result` <= imm, go to DONE.
- **DECODE, POP:**
  - `q_count` == 0 → ERROR, code 1.
  - Otherwise assert `q_pop`, `result` <= `q_dout`, go to DONE.
- **DECODE, binary ops (2–6):**
  - `q_count` < 2 → ERROR, code 1. No pop is issued.
  - Otherwise assert `q_pop`, latch A = `q_dout`, go to POP_B.
- **DECODE, NOP:** go to DONE with no queue activity.
- **DECODE, op 7:** go to ERROR, code 0.
- **POP_B:** assert `q_pop`, latch B = `q_dout`, go to EXEC.
- **EXEC, results (all mod 256, unsigned):**
  - ADD: A+B.
  - MUL: low 8 bits of A*B.
  - SUB: A−B.
  - DIV: A/B, truncating.
  - REM: A%B.
- **EXEC, action:**
  - DIV or REM with B == 0 → ERROR, code 3. Both operands are already consumed; nothing is pushed.
  - Otherwise assert `q_push`, `q_din` = result, `result` <= value, go to DONE.
  - Overflow is impossible here because two entries were just popped.
- **DONE:** `done` = 1 for exactly one cycle, then go to IDLE.
- **ERROR:**
  - `err` = 1, `instr_ready` = 0, no queue strobes.
  - `err_clr` = 1 → IDLE; `err` and `err_code` clear at that same edge.
- **Queue strobes:** `q_pop` and `q_push` are never asserted in the same cycle.

## Timing
- **Reset:** `rst` = 1 at an edge forces IDLE and zeroes `result`, `err`, `err_code`, `done` and the A/B latches. All strobes are 0 and `instr_ready` = 0 while `rst` is high.
- **Reset mid-instruction:** aborts the instruction. No further strobes after that edge. Pops already issued are not undone.
- **Latency, counted from the accept edge:**
  - PUSH, POP, NOP: `done` high in cycle +2.
  - Binary op: `done` high in cycle +4.
  - Next accept possible in cycle +3 or +5 respectively.
- **Strobe cycles:**
  - `q_push` / `q_pop` are asserted combinationally in the stated state.
  - Each is high for exactly one cycle per queue access.
  - The queue updates `q_count` / `q_dout` at the same edge.
- **Outputs:** `result` updates at the edge leaving DECODE or EXEC. It holds through DONE and IDLE until the next push or pop.
- **Handshake:** `instr_valid` held while `instr_ready` = 0 is not accepted. An instruction presented in the cycle `err_clr` is taken is not accepted; the earliest accept is the following cycle.
- **Error timing:** `err` rises on the edge entering ERROR and stays high until `err_clr` or `rst`.

## Test plan
- PUSH 7, PUSH 5, SUB → pops A=7 then B=5; `q_push` with `q_din` = 2; `result` = 2; `done` at +4; `q_count` ends at 1.
- PUSH 200, PUSH 100, ADD → `q_din` = 44 (mod 256). PUSH 16, PUSH 16, MUL → `q_din` = 0.
- PUSH 9, PUSH 0, DIV → two pops, no push; `err` = 1, `err_code` = 3; `instr_ready` = 0 until `err_clr`; then IDLE with `err` = 0.
- Empty queue, POP → no `q_pop`; `err_code` = 1. With `q_count` = 1, ADD → no pop; `err_code` = 1.
- `q_count` == DEPTH, PUSH 3 → no `q_push`; `err_code` = 2. Opcode 7 → `err_code` = 0. Opcode 12 → `done` at +2, no strobes.
- `rst` asserted in the POP_B cycle of a MUL → no `q_pop` that cycle; all outputs 0 next cycle; a fresh PUSH 1 is accepted after `rst` drops.
